voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
Polyphony scheduler between the key-press bitmap (FSR/KEY_MIXER side) and a fixed pool of karplus_note voices. It detects note-on and note-off edges per key and assigns each note-on to a voice. It drives each voice's key index, gate and one-cycle trigger, and times each voice's release tail in audio sample ticks. When every voice is in use, it steals one.

Parameters:
NUM_KEYS, 17, width of key bitmap
NUM_VOICES, 4, voices in pool
KEY_W, 5, key index width (ceil log2 NUM_KEYS)
REL_SAMPLES, 4800, release tail length in sample ticks (0 allowed)
AGE_W, 8, per-voice age counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
key_state  in  NUM_KEYS  level bitmap, 1=key held, synchronous to clk
sample_tick  in  1  one-cycle pulse per audio sample (DACLRCK edge, detected upstream)
voice_key  out  NUM_VOICES*KEY_W  key index per voice, voice v at [v*KEY_W +: KEY_W]
voice_busy  out  NUM_VOICES  voice not FREE
voice_gate  out  NUM_VOICES  voice HELD
voice_trig  out  NUM_VOICES  one-cycle pulse on (re)allocation; restarts excitation
steal_evt  out  1  one-cycle pulse when a HELD voice is stolen
active_count  out  clog2(NUM_VOICES+1)  number of busy voices

Behaviour:
- Reset: all voices FREE, voice_key=0, busy/gate/trig=0, steal_evt=0, active_count=0, key_seen=0, ages=0, release counters=0, FSM=IDLE.
- key_seen register (NUM_KEYS bits): on_pend = key_state & ~key_seen; off_pend = ~key_state & key_seen.
- Per-voice state: FREE, HELD, RELEASE. Each voice also holds key index, age (AGE_W) and release counter (16 bit).
- FSM:
  - IDLE: if off_pend != 0, latch the lowest-index off key and go to COMMIT. Else if on_pend != 0, latch the lowest-index on key and go to COMMIT. Else stay. Off events take priority over on events.
  - COMMIT: apply the event, update the key_seen bit, return to IDLE. Throughput is one event per 2 cycles.
- Latency: key edge first sampled at edge N; voice registers and voice_trig are visible from edge N+2.
- Note-off for key k:
  - The HELD voice with voice_key==k goes to RELEASE, gate=0, counter=REL_SAMPLES.
  - If REL_SAMPLES==0 it goes directly to FREE.
  - If no such voice exists (it was stolen), only clear key_seen[k].
- Note-on for key k, selection priority:
  (1) a RELEASE voice already holding k (retrigger);
  (2) the lowest-index FREE voice;
  (3) the RELEASE voice with the largest age;
  (4) the HELD voice with the largest age; set steal_evt.
  - Age ties resolve to the lowest index.
  - The chosen voice becomes HELD: key=k, age=0, gate=1, voice_trig pulses one cycle.
- sample_tick:
  - Each busy voice's age increments, saturating at 2^AGE_W-1.
  - Each RELEASE counter decrements. At 1→0 the voice goes FREE; voice_key keeps its last value.
  - If the tick coincides with COMMIT on the same voice, the commit wins (age=0, counter loaded, no decrement).
- voice_trig and steal_evt are registered pulses, exactly one cycle wide.
- A key released and re-pressed within the same IDLE window (no off_pend seen) generates no event.
- active_count is registered and consistent with voice_busy in the same cycle.
- Reset mid-operation: everything returns to reset values. Keys still held after reset deasserts are re-allocated as new note-ons, starting at voice 0.

Test Plan:
1. Reset, then key_state=0x00002 at edge N → voice_trig=0001 for exactly the cycle after N+2, voice_key[0]=1, busy=0001, gate=0001, active_count=1.
2. REL_SAMPLES=4. Hold key 1, then clear it → gate=0000 two cycles later and busy stays 0001. After the 4th sample_tick, busy=0000 and active_count=0.
3. key_state changes 0→0x0000E in one cycle → voices 0,1,2 get keys 1,2,3. Trigs at N+2, N+4, N+6. active_count=3.
4. NUM_VOICES=4. Press keys 1..4 in turn with sample_ticks between, then press key 5 → voice 0 (oldest) gets key 5, steal_evt and voice_trig[0] pulse once. A later release of key 1 changes nothing.
5. Press key 4, release it, press key 4 again before the release expires → the same voice retriggers (trig pulse, gate=1). No other voice changes and active_count is unchanged.
6. Keys 1,2 held, assert reset for 1 cycle → all outputs 0 the next cycle. After deassert, keys 1,2 are re-allocated to voices 0,1 with trig pulses.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphony scheduler: turns key-press edges into voice allocations,
// release-tail timing and voice stealing for a fixed karplus_note pool.
module voice_allocator #(
  parameter int NUM_KEYS    = 17,
  parameter int NUM_VOICES  = 4,
  parameter int KEY_W       = 5,
  parameter int REL_SAMPLES = 4800,
  parameter int AGE_W       = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_KEYS-1:0]                   key_state,
  input  logic                                  sample_tick,
  output logic [NUM_VOICES*KEY_W-1:0]           voice_key,
  output logic [NUM_VOICES-1:0]                 voice_busy,
  output logic [NUM_VOICES-1:0]                 voice_gate,
  output logic [NUM_VOICES-1:0]                 voice_trig,
  output logic                                  steal_evt,
  output logic [$clog2(NUM_VOICES+1)-1:0]       active_count
);

  localparam int CNT_W = $clog2(NUM_VOICES + 1);
  localparam int VI_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
  localparam logic [15:0]      REL_LOAD = 16'(REL_SAMPLES);

  typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vst_e;
  typedef enum logic {S_IDLE, S_COMMIT} fsm_e;

  logic [NUM_KEYS-1:0] key_in_q;
  logic [NUM_KEYS-1:0] key_seen_q, key_seen_d;
  fsm_e                fsm_q, fsm_d;
  logic [KEY_W-1:0]    ev_key_q, ev_key_d;
  logic                ev_on_q, ev_on_d;

  vst_e             vst_q  [NUM_VOICES];
  vst_e             vst_d  [NUM_VOICES];
  logic [KEY_W-1:0] vkey_q [NUM_VOICES];
  logic [KEY_W-1:0] vkey_d [NUM_VOICES];
  logic [AGE_W-1:0] age_q  [NUM_VOICES];
  logic [AGE_W-1:0] age_d  [NUM_VOICES];
  logic [15:0]      rel_q  [NUM_VOICES];
  logic [15:0]      rel_d  [NUM_VOICES];

  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic                  steal_q, steal_d;
  logic [CNT_W-1:0]      act_q, act_d;

  logic [NUM_KEYS-1:0] on_pend, off_pend;
  logic [KEY_W-1:0]    on_idx, off_idx;
  logic                latch_en, commit;

  logic            off_hit, rt_hit, free_hit, rel_hit;
  logic [VI_W-1:0] off_sel, rt_sel, free_sel, rel_sel, held_sel, on_sel;
  logic [AGE_W-1:0] rel_age, held_age;
  logic            steal_need;

  assign on_pend  = key_in_q & ~key_seen_q;
  assign off_pend = ~key_in_q & key_seen_q;

  always_comb begin
    on_idx  = '0;
    off_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (on_pend[i])  on_idx  = KEY_W'(i);
      if (off_pend[i]) off_idx = KEY_W'(i);
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  // FSM: next state
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      S_IDLE:   if (|off_pend || |on_pend) fsm_d = S_COMMIT;
      S_COMMIT: fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    latch_en = 1'b0;
    commit   = 1'b0;
    unique case (fsm_q)
      S_IDLE:   latch_en = |off_pend || |on_pend;
      S_COMMIT: commit   = 1'b1;
      default:  ;
    endcase
  end

  // Off events win over on events
  always_comb begin
    ev_key_d = ev_key_q;
    ev_on_d  = ev_on_q;
    if (latch_en) begin
      ev_on_d  = ~|off_pend;
      ev_key_d = (|off_pend) ? off_idx : on_idx;
    end
    key_seen_d = key_seen_q;
    if (commit) key_seen_d[ev_key_q] = ev_on_q;
  end

  always_comb begin
    off_hit  = 1'b0; off_sel  = '0;
    rt_hit   = 1'b0; rt_sel   = '0;
    free_hit = 1'b0; free_sel = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (vst_q[v] == V_HELD && vkey_q[v] == ev_key_q) begin
        off_hit = 1'b1; off_sel = VI_W'(v);
      end
      if (vst_q[v] == V_REL && vkey_q[v] == ev_key_q) begin
        rt_hit = 1'b1; rt_sel = VI_W'(v);
      end
      if (vst_q[v] == V_FREE) begin
        free_hit = 1'b1; free_sel = VI_W'(v);
      end
    end
  end

  // Oldest voice per class; strict compare keeps the lowest index on ties
  always_comb begin
    rel_hit  = 1'b0; rel_sel  = '0; rel_age  = '0;
    held_sel = '0;   held_age = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (vst_q[v] == V_REL && (!rel_hit || age_q[v] > rel_age)) begin
        rel_hit = 1'b1; rel_sel = VI_W'(v); rel_age = age_q[v];
      end
    end
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (vst_q[v] == V_HELD && age_q[v] >= held_age) begin
        held_sel = VI_W'(v); held_age = age_q[v];
      end
    end
  end

  always_comb begin
    steal_need = 1'b0;
    if (rt_hit)        on_sel = rt_sel;
    else if (free_hit) on_sel = free_sel;
    else if (rel_hit)  on_sel = rel_sel;
    else begin
      on_sel     = held_sel;
      steal_need = 1'b1;
    end
  end

  always_comb begin
    trig_d  = '0;
    steal_d = commit && ev_on_q && steal_need;
    act_d   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      vst_d[v]  = vst_q[v];
      vkey_d[v] = vkey_q[v];
      age_d[v]  = age_q[v];
      rel_d[v]  = rel_q[v];
      if (sample_tick && vst_q[v] != V_FREE && age_q[v] != AGE_MAX)
        age_d[v] = age_q[v] + 1'b1;
      if (sample_tick && vst_q[v] == V_REL) begin
        rel_d[v] = (rel_q[v] == 16'd0) ? 16'd0 : rel_q[v] - 16'd1;
        if (rel_q[v] <= 16'd1) vst_d[v] = V_FREE;
      end
      if (commit && ev_on_q && VI_W'(v) == on_sel) begin
        vst_d[v]  = V_HELD;
        vkey_d[v] = ev_key_q;
        age_d[v]  = '0;
        rel_d[v]  = '0;
        trig_d[v] = 1'b1;
      end
      if (commit && !ev_on_q && off_hit && VI_W'(v) == off_sel) begin
        vst_d[v] = (REL_SAMPLES == 0) ? V_FREE : V_REL;
        age_d[v] = age_q[v];
        rel_d[v] = REL_LOAD;
      end
      if (vst_d[v] != V_FREE) act_d = act_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_in_q   <= '0;
      key_seen_q <= '0;
      ev_key_q   <= '0;
      ev_on_q    <= 1'b0;
      trig_q     <= '0;
      steal_q    <= 1'b0;
      act_q      <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vst_q[v]  <= V_FREE;
        vkey_q[v] <= '0;
        age_q[v]  <= '0;
        rel_q[v]  <= '0;
      end
    end else begin
      key_in_q   <= key_state;
      key_seen_q <= key_seen_d;
      ev_key_q   <= ev_key_d;
      ev_on_q    <= ev_on_d;
      trig_q     <= trig_d;
      steal_q    <= steal_d;
      act_q      <= act_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vst_q[v]  <= vst_d[v];
        vkey_q[v] <= vkey_d[v];
        age_q[v]  <= age_d[v];
        rel_q[v]  <= rel_d[v];
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_key[v*KEY_W +: KEY_W] = vkey_q[v];
      voice_busy[v] = (vst_q[v] != V_FREE);
      voice_gate[v] = (vst_q[v] == V_HELD);
    end
  end

  assign voice_trig   = trig_q;
  assign steal_evt    = steal_q;
  assign active_count = act_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: per-cycle vector table plus
// hand-written steal, retrigger and mid-run reset sequences.
module tb_voice_allocator;

  logic        clk;
  logic        reset;
  logic [16:0] key_state;
  logic        sample_tick;
  logic [19:0] voice_key;
  logic [3:0]  voice_busy, voice_gate, voice_trig;
  logic        steal_evt;
  logic [2:0]  active_count;

  int total = 0;
  int bad   = 0;

  voice_allocator #(
    .NUM_KEYS(17), .NUM_VOICES(4), .KEY_W(5),
    .REL_SAMPLES(4), .AGE_W(8)
  ) dut (
    .clk(clk), .reset(reset), .key_state(key_state),
    .sample_tick(sample_tick), .voice_key(voice_key),
    .voice_busy(voice_busy), .voice_gate(voice_gate),
    .voice_trig(voice_trig), .steal_evt(steal_evt),
    .active_count(active_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [16:0] keys;
    logic        tick;
    logic [3:0]  busy;
    logic [3:0]  gate;
    logic [3:0]  trig;
    logic        steal;
    logic [2:0]  act;
    logic [19:0] vkey;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic r, logic [16:0] k, logic t,
                              logic [3:0] b, logic [3:0] g,
                              logic [3:0] tr, logic s,
                              logic [2:0] a, logic [19:0] vk);
    vec_t x;
    x.rst = r; x.keys = k; x.tick = t; x.busy = b; x.gate = g;
    x.trig = tr; x.steal = s; x.act = a; x.vkey = vk;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic cyc(logic [16:0] k, logic t, logic r);
    @(negedge clk);
    reset = r;
    key_state = k;
    sample_tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string nm, logic [3:0] b, logic [3:0] g,
                         logic [3:0] tr, logic s, logic [2:0] a,
                         logic [19:0] vk);
    chk({nm, ".busy"},  32'(voice_busy),   32'(b));
    chk({nm, ".gate"},  32'(voice_gate),   32'(g));
    chk({nm, ".trig"},  32'(voice_trig),   32'(tr));
    chk({nm, ".steal"}, 32'(steal_evt),    32'(s));
    chk({nm, ".act"},   32'(active_count), 32'(a));
    chk({nm, ".vkey"},  32'(voice_key),    32'(vk));
  endtask

  initial begin
    logic [16:0] keys;
    clk = 1'b0;
    reset = 1'b1;
    key_state = '0;
    sample_tick = 1'b0;

    // reset, single note-on, release tail, multi-key burst
    vecs[0]  = mk(1, 17'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 20'h0);
    vecs[1]  = mk(0, 17'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 20'h0);
    vecs[2]  = mk(0, 17'h2, 0, 4'h0, 4'h0, 4'h0, 0, 0, 20'h0);
    vecs[3]  = mk(0, 17'h2, 0, 4'h0, 4'h0, 4'h0, 0, 0, 20'h0);
    vecs[4]  = mk(0, 17'h2, 0, 4'h1, 4'h1, 4'h1, 0, 1, 20'h1);
    vecs[5]  = mk(0, 17'h2, 0, 4'h1, 4'h1, 4'h0, 0, 1, 20'h1);
    vecs[6]  = mk(0, 17'h0, 0, 4'h1, 4'h1, 4'h0, 0, 1, 20'h1);
    vecs[7]  = mk(0, 17'h0, 0, 4'h1, 4'h1, 4'h0, 0, 1, 20'h1);
    vecs[8]  = mk(0, 17'h0, 0, 4'h1, 4'h0, 4'h0, 0, 1, 20'h1);
    vecs[9]  = mk(0, 17'h0, 1, 4'h1, 4'h0, 4'h0, 0, 1, 20'h1);
    vecs[10] = mk(0, 17'h0, 1, 4'h1, 4'h0, 4'h0, 0, 1, 20'h1);
    vecs[11] = mk(0, 17'h0, 1, 4'h1, 4'h0, 4'h0, 0, 1, 20'h1);
    vecs[12] = mk(0, 17'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 20'h1);
    vecs[13] = mk(0, 17'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 20'h1);
    vecs[14] = mk(0, 17'hE, 0, 4'h0, 4'h0, 4'h0, 0, 0, 20'h1);
    vecs[15] = mk(0, 17'hE, 0, 4'h0, 4'h0, 4'h0, 0, 0, 20'h1);
    vecs[16] = mk(0, 17'hE, 0, 4'h1, 4'h1, 4'h1, 0, 1, 20'h1);
    vecs[17] = mk(0, 17'hE, 0, 4'h1, 4'h1, 4'h0, 0, 1, 20'h1);
    vecs[18] = mk(0, 17'hE, 0, 4'h3, 4'h3, 4'h2, 0, 2, 20'h41);
    vecs[19] = mk(0, 17'hE, 0, 4'h3, 4'h3, 4'h0, 0, 2, 20'h41);
    vecs[20] = mk(0, 17'hE, 0, 4'h7, 4'h7, 4'h4, 0, 3, 20'hC41);
    vecs[21] = mk(0, 17'hE, 0, 4'h7, 4'h7, 4'h0, 0, 3, 20'hC41);

    for (int i = 0; i < 22; i++) begin
      cyc(vecs[i].keys, vecs[i].tick, vecs[i].rst);
      chk_all($sformatf("vec%0d", i), vecs[i].busy, vecs[i].gate,
              vecs[i].trig, vecs[i].steal, vecs[i].act, vecs[i].vkey);
    end

    // steal the oldest held voice
    cyc(17'h0, 0, 1);
    keys = '0;
    for (int k = 1; k <= 4; k++) begin
      keys[k] = 1'b1;
      repeat (6) cyc(keys, 0, 0);
      cyc(keys, 1, 0);
    end
    chk_all("fill", 4'hF, 4'hF, 4'h0, 0, 4, 20'h20C41);
    keys[5] = 1'b1;
    cyc(keys, 0, 0);
    cyc(keys, 0, 0);
    chk_all("steal_pre", 4'hF, 4'hF, 4'h0, 0, 4, 20'h20C41);
    cyc(keys, 0, 0);
    chk_all("steal", 4'hF, 4'hF, 4'h1, 1, 4, 20'h20C45);
    cyc(keys, 0, 0);
    chk_all("steal_post", 4'hF, 4'hF, 4'h0, 0, 4, 20'h20C45);
    keys[1] = 1'b0;
    repeat (6) cyc(keys, 0, 0);
    chk_all("stolen_off", 4'hF, 4'hF, 4'h0, 0, 4, 20'h20C45);

    // retrigger a releasing voice
    cyc(17'h0, 0, 1);
    repeat (8) cyc(17'h14, 0, 0);
    chk_all("rt_hold", 4'h3, 4'h3, 4'h0, 0, 2, 20'h82);
    repeat (6) cyc(17'h04, 0, 0);
    chk_all("rt_rel", 4'h3, 4'h1, 4'h0, 0, 2, 20'h82);
    cyc(17'h14, 0, 0);
    cyc(17'h14, 0, 0);
    cyc(17'h14, 0, 0);
    chk_all("rt_trig", 4'h3, 4'h3, 4'h2, 0, 2, 20'h82);
    cyc(17'h14, 0, 0);
    chk_all("rt_post", 4'h3, 4'h3, 4'h0, 0, 2, 20'h82);

    // reset while keys are held
    cyc(17'h0, 0, 1);
    repeat (8) cyc(17'h6, 0, 0);
    chk_all("mr_hold", 4'h3, 4'h3, 4'h0, 0, 2, 20'h41);
    cyc(17'h6, 0, 1);
    chk_all("mr_rst", 4'h0, 4'h0, 4'h0, 0, 0, 20'h0);
    cyc(17'h6, 0, 0);
    cyc(17'h6, 0, 0);
    chk_all("mr_wait", 4'h0, 4'h0, 4'h0, 0, 0, 20'h0);
    cyc(17'h6, 0, 0);
    chk_all("mr_v0", 4'h1, 4'h1, 4'h1, 0, 1, 20'h1);
    cyc(17'h6, 0, 0);
    cyc(17'h6, 0, 0);
    chk_all("mr_v1", 4'h3, 4'h3, 4'h2, 0, 2, 20'h41);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
